// File: rtl/hsv_pkg.sv
// Shared constants for the HSV->RGB pipeline: latency, hue sectors, pixel field positions.
package hsv_pkg;

    localparam int HSV2RGB_LATENCY = 3;

    localparam logic [2:0] SEC_0 = 3'd0;
    localparam logic [2:0] SEC_1 = 3'd1;
    localparam logic [2:0] SEC_2 = 3'd2;
    localparam logic [2:0] SEC_3 = 3'd3;
    localparam logic [2:0] SEC_4 = 3'd4;
    localparam logic [2:0] SEC_5 = 3'd5;

    // LSB of each 8-bit channel within a 24-bit pixel word
    localparam int H_LSB = 16;
    localparam int S_LSB = 8;
    localparam int V_LSB = 0;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

endpackage

// File: rtl/hsv_scale8.sv
// Combinational 8x8 unsigned scale: (a*b)>>8, with +128 rounding when HSV2RGB_ROUND_EN is defined.
module hsv_scale8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    logic [15:0] prod;

    always_comb begin
`ifdef HSV2RGB_ROUND_EN
        // 255*255+128 still fits in 16 bits, so no carry out is lost
        prod = ({8'd0, a} * {8'd0, b}) + 16'd128;
`else
        prod = {8'd0, a} * {8'd0, b};
`endif
        y = 8'(prod >> 8);
    end

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Three-stage HSV->RGB converter with delay-matched valid/sync/blank side channel.
// Build option: HSV2RGB_ROUND_EN selects rounded instead of truncated products.
module hsv2rgb_pipe
    import hsv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] hsv_in,
    input  logic        in_valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    output logic [23:0] rgb_out,
    output logic        out_valid,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    logic [7:0]  h_in, s_in, v_in;
    logic [10:0] h6;
    logic [7:0]  f;
    logic [7:0]  sf_nx, sg_nx;

    logic [7:0]  s1_v, s1_s, s1_sx, s1_sf, s1_sg;
    logic [2:0]  s1_sector;

    logic [7:0]  p_nx, q_nx, t_nx;
    logic [7:0]  s2_v, s2_p, s2_q, s2_t;
    logic [2:0]  s2_sector;
    logic        s2_grey;

    logic [7:0]  r_nx, g_nx, b_nx;

    logic [HSV2RGB_LATENCY-1:0][3:0] side_sr;

    assign h_in = hsv_in[H_LSB +: 8];
    assign s_in = hsv_in[S_LSB +: 8];
    assign v_in = hsv_in[V_LSB +: 8];

    // H in 0..255 maps onto six sectors of 256 fractional steps each
    assign h6 = {3'd0, h_in} * 11'd6;
    assign f  = h6[7:0];

    hsv_scale8 u_sf (.a(s_in), .b(f),  .y(sf_nx));
    hsv_scale8 u_sg (.a(s_in), .b(~f), .y(sg_nx));

    hsv_scale8 u_p (.a(s1_v), .b(s1_sx),  .y(p_nx));
    hsv_scale8 u_q (.a(s1_v), .b(~s1_sf), .y(q_nx));
    hsv_scale8 u_t (.a(s1_v), .b(~s1_sg), .y(t_nx));

    always_comb begin
        r_nx = s2_v;
        g_nx = s2_p;
        b_nx = s2_q;
        case (s2_sector)
            SEC_0: begin r_nx = s2_v; g_nx = s2_t; b_nx = s2_p; end
            SEC_1: begin r_nx = s2_q; g_nx = s2_v; b_nx = s2_p; end
            SEC_2: begin r_nx = s2_p; g_nx = s2_v; b_nx = s2_t; end
            SEC_3: begin r_nx = s2_p; g_nx = s2_q; b_nx = s2_v; end
            SEC_4: begin r_nx = s2_t; g_nx = s2_p; b_nx = s2_v; end
            SEC_5: begin r_nx = s2_v; g_nx = s2_p; b_nx = s2_q; end
            default: begin r_nx = s2_v; g_nx = s2_p; b_nx = s2_q; end
        endcase
        // zero saturation must give exact grey regardless of product truncation
        if (s2_grey) begin
            r_nx = s2_v;
            g_nx = s2_v;
            b_nx = s2_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= '0;
            s1_s      <= '0;
            s1_sx     <= '0;
            s1_sf     <= '0;
            s1_sg     <= '0;
            s1_sector <= '0;
            s2_v      <= '0;
            s2_p      <= '0;
            s2_q      <= '0;
            s2_t      <= '0;
            s2_sector <= '0;
            s2_grey   <= 1'b0;
            rgb_out   <= '0;
            side_sr   <= '0;
        end else begin
            s1_v      <= v_in;
            s1_s      <= s_in;
            s1_sx     <= ~s_in;
            s1_sf     <= sf_nx;
            s1_sg     <= sg_nx;
            s1_sector <= h6[10:8];
            s2_v      <= s1_v;
            s2_p      <= p_nx;
            s2_q      <= q_nx;
            s2_t      <= t_nx;
            s2_sector <= s1_sector;
            s2_grey   <= (s1_s == 8'd0);
            rgb_out[R_LSB +: 8] <= r_nx;
            rgb_out[G_LSB +: 8] <= g_nx;
            rgb_out[B_LSB +: 8] <= b_nx;
            side_sr   <= {side_sr[HSV2RGB_LATENCY-2:0], {in_valid, hsync_in, vsync_in, blank_in}};
        end
    end

    assign {out_valid, hsync_out, vsync_out, blank_out} = side_sr[HSV2RGB_LATENCY-1];

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Directed and random-stream checks of hsv2rgb_pipe; expectations follow HSV2RGB_ROUND_EN if defined.
module tb_hsv2rgb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] hsv_in;
    logic        in_valid, hsync_in, vsync_in, blank_in;
    logic [23:0] rgb_out;
    logic        out_valid, hsync_out, vsync_out, blank_out;

    int checks = 0;
    int errors = 0;

`ifdef HSV2RGB_ROUND_EN
    localparam logic [23:0] EXP_H0   = 24'hFF0100;
    localparam logic [23:0] EXP_H43  = 24'hFCFF00;
    localparam logic [23:0] EXP_H128 = 24'h00FEFF;
`else
    localparam logic [23:0] EXP_H0   = 24'hFF0000;
    localparam logic [23:0] EXP_H43  = 24'hFDFF00;
    localparam logic [23:0] EXP_H128 = 24'h00FEFF;
`endif

    hsv2rgb_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .hsv_in    (hsv_in),
        .in_valid  (in_valid),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .blank_in  (blank_in),
        .rgb_out   (rgb_out),
        .out_valid (out_valid),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model(input logic [23:0] hsv);
        int h, s, v, h6, sec, f, sf, sg, p, q, t, r, g, b, rnd;
        rnd = 0;
`ifdef HSV2RGB_ROUND_EN
        rnd = 128;
`endif
        h = int'(hsv[23:16]);
        s = int'(hsv[15:8]);
        v = int'(hsv[7:0]);
        h6  = h * 6;
        sec = h6 / 256;
        f   = h6 % 256;
        sf  = (s * f + rnd) / 256;
        sg  = (s * (255 - f) + rnd) / 256;
        p   = (v * (255 - s) + rnd) / 256;
        q   = (v * (255 - sf) + rnd) / 256;
        t   = (v * (255 - sg) + rnd) / 256;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        if (s == 0) begin
            r = v; g = v; b = v;
        end
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic drive(input logic [23:0] hsv, input logic [3:0] side);
        hsv_in = hsv;
        {in_valid, hsync_in, vsync_in, blank_in} = side;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(24'h123456, 4'b1111);
        step();
        step();
        if (rgb_out !== 24'h0) begin
            errors++; $display("FAIL reset_rgb got %h want %h", rgb_out, 24'h0);
        end
        checks++;
        if ({out_valid, hsync_out, vsync_out, blank_out} !== 4'b0000) begin
            errors++; $display("FAIL reset_side got %b want 0000", {out_valid, hsync_out, vsync_out, blank_out});
        end
        checks++;
        drive(24'h0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_latency;
        drive(24'h00FFFF, 4'b1000);
        for (int k = 0; k < 4; k++) begin
            step();
            drive(24'h0, 4'b0000);
            if (k < 2) begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL latency_early_valid cyc %0d got %b want 0", k + 1, out_valid);
                end
                checks++;
            end else if (k == 2) begin
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL latency_valid got %b want 1", out_valid);
                end
                checks++;
                if (rgb_out !== EXP_H0) begin
                    errors++; $display("FAIL latency_red_rgb got %h want %h", rgb_out, EXP_H0);
                end
                checks++;
            end else begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL latency_late_valid got %b want 0", out_valid);
                end
                checks++;
            end
        end
    endtask

    task automatic test_hue_points;
        logic [23:0] vin [3];
        logic [23:0] vexp [3];
        vin[0] = 24'h00FFFF; vexp[0] = EXP_H0;
        vin[1] = 24'h2BFFFF; vexp[1] = EXP_H43;
        vin[2] = 24'h80FFFF; vexp[2] = EXP_H128;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(vin[k], 4'b1000);
            else       drive(24'h0, 4'b0000);
            step();
            if (k >= 2) begin
                if (rgb_out !== vexp[k-2]) begin
                    errors++; $display("FAIL hue_point %0d got %h want %h", k - 2, rgb_out, vexp[k-2]);
                end
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL hue_point_valid %0d got %b want 1", k - 2, out_valid);
                end
                checks++;
            end
        end
    endtask

    task automatic test_grey;
        for (int k = 0; k < 258; k++) begin
            if (k < 256) drive({8'(k), 8'd0, 8'd200}, 4'b1000);
            else         drive(24'h0, 4'b0000);
            step();
            if (k >= 2) begin
                if (rgb_out !== 24'hC8C8C8 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL grey H=%0d got %h/%b want c8c8c8/1", k - 2, rgb_out, out_valid);
                end
                checks++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] hq [64];
        logic [3:0]  sq [64];
        for (int k = 0; k < 66; k++) begin
            if (k < 64) begin
                hq[k] = 24'($urandom);
                sq[k] = 4'($urandom_range(0, 15));
                drive(hq[k], sq[k]);
            end else begin
                drive(24'h0, 4'b0000);
            end
            step();
            if (k >= 2) begin
                if (rgb_out !== model(hq[k-2])) begin
                    errors++; $display("FAIL stream_rgb idx %0d hsv %h got %h want %h", k - 2, hq[k-2], rgb_out, model(hq[k-2]));
                end
                checks++;
                if ({out_valid, hsync_out, vsync_out, blank_out} !== sq[k-2]) begin
                    errors++; $display("FAIL stream_side idx %0d got %b want %b", k - 2, {out_valid, hsync_out, vsync_out, blank_out}, sq[k-2]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        for (int k = 0; k < 4; k++) begin
            drive(24'h00FFFF, 4'b1111);
            step();
        end
        #2;
        rst = 1'b1;
        drive(24'h0, 4'b0000);
        #1;
        if (rgb_out !== 24'h0 || {out_valid, hsync_out, vsync_out, blank_out} !== 4'b0000) begin
            errors++; $display("FAIL midreset_async got %h/%b want 000000/0000", rgb_out, {out_valid, hsync_out, vsync_out, blank_out});
        end
        checks++;
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (rgb_out !== 24'h0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_idle cyc %0d got %h/%b want 000000/0", k, rgb_out, out_valid);
            end
            checks++;
        end
        drive(24'h00FFFF, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            step();
            drive(24'h0, 4'b0000);
            if (k < 2) begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL midreset_early_valid cyc %0d got %b want 0", k + 1, out_valid);
                end
                checks++;
            end else begin
                if (out_valid !== 1'b1 || rgb_out !== EXP_H0) begin
                    errors++; $display("FAIL midreset_first got %h/%b want %h/1", rgb_out, out_valid, EXP_H0);
                end
                checks++;
            end
        end
    endtask

    initial begin
        drive(24'h0, 4'b0000);
        test_reset();
        test_latency();
        test_hue_points();
        test_grey();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
